// File: rtl/qm_pkg.sv
// Shared MIPS32 decode constants: opcodes, instruction field positions,
// register-address type and the DE pipeline register layout.
package qm_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd31;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] ir;
    logic [31:0] next_pc;
    reg_addr_t   dest;
    logic        is_load;
    logic        valid;
  } de_t;

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/qm_regfile.sv
// 32x32 general-purpose register file: two combinational read ports, one
// write port, $0 hard-wired to zero. QM_DECODE_BYPASS_EN enables write-through.
module qm_regfile
  import qm_pkg::*;
(
  input  logic        sys_clk,
  input  logic        reset,
  input  reg_addr_t   rd_addr_a,
  input  reg_addr_t   rd_addr_b,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b,
  input  logic        wr_en,
  input  reg_addr_t   wr_addr,
  input  logic [31:0] wr_data
);

`ifdef QM_DECODE_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        wr_live;

  assign wr_live = wr_en && (wr_addr != REG_ZERO);

  always_comb begin
    regs_d = regs_q;
    if (wr_live) begin
      regs_d[wr_addr] = wr_data;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data_a = (rd_addr_a == REG_ZERO) ? 32'h0 : regs_q[rd_addr_a];
    rd_data_b = (rd_addr_b == REG_ZERO) ? 32'h0 : regs_q[rd_addr_b];
    // Write-through only exists in the bypass build; otherwise the pre-write value is seen.
    if (BYPASS && wr_live && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
    if (BYPASS && wr_live && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
  end

endmodule

// File: rtl/qm_decode.sv
// q3kmips decode stage: register read, immediate/dest generation, load-use
// bubble insertion and the Decode/Execute register. See QM_DECODE_BYPASS_EN.
module qm_decode
  import qm_pkg::*;
(
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [31:0] di_IR,
  input  logic [31:0] di_NextPC,
  input  logic        di_valid,
  input  logic        ex_stall,
  input  logic        wb_enable,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        do_stall,
  output logic [31:0] do_A,
  output logic [31:0] do_B,
  output logic [31:0] do_Imm,
  output logic [31:0] do_IR,
  output logic [31:0] do_NextPC,
  output logic [4:0]  do_Dest,
  output logic        do_is_load,
  output logic        do_valid
);

  de_t         de_q, de_d;
  logic [5:0]  opcode;
  reg_addr_t   rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] rs_data, rt_data;
  logic [31:0] imm_ext;
  reg_addr_t   dest;
  logic        hazard;

  assign opcode = di_IR[OP_MSB:OP_LSB];
  assign rs     = di_IR[RS_MSB:RS_LSB];
  assign rt     = di_IR[RT_MSB:RT_LSB];
  assign rd     = di_IR[RD_MSB:RD_LSB];
  assign imm16  = di_IR[IMM_MSB:IMM_LSB];

  qm_regfile u_regfile (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .rd_addr_a (rs),
    .rd_addr_b (rt),
    .rd_data_a (rs_data),
    .rd_data_b (rt_data),
    .wr_en     (wb_enable),
    .wr_addr   (wb_reg),
    .wr_data   (wb_data)
  );

  always_comb begin
    imm_ext = {{16{imm16[15]}}, imm16};
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: imm_ext = {16'h0, imm16};
      OP_LUI:                   imm_ext = {imm16, 16'h0};
      default: ;
    endcase
  end

  always_comb begin
    dest = REG_ZERO;
    case (opcode)
      OP_SPECIAL: dest = rd;
      OP_JAL:     dest = REG_RA;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: dest = rt;
      default: ;
    endcase
  end

  // The loaded value is not available until after execute, so a consumer one slot behind must wait.
  assign hazard = de_q.valid && de_q.is_load && (de_q.dest != REG_ZERO) && di_valid &&
                  ((de_q.dest == rs) || (de_q.dest == rt));

  assign do_stall = ex_stall | hazard;

  always_comb begin
    de_d = de_q;
    if (!ex_stall) begin
      if (hazard || !di_valid) begin
        de_d = '0;
      end else begin
        de_d.a       = rs_data;
        de_d.b       = rt_data;
        de_d.imm     = imm_ext;
        de_d.ir      = di_IR;
        de_d.next_pc = di_NextPC;
        de_d.dest    = dest;
        de_d.is_load = is_load_op(opcode);
        de_d.valid   = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      de_q <= '0;
    end else begin
      de_q <= de_d;
    end
  end

  assign do_A       = de_q.a;
  assign do_B       = de_q.b;
  assign do_Imm     = de_q.imm;
  assign do_IR      = de_q.ir;
  assign do_NextPC  = de_q.next_pc;
  assign do_Dest    = de_q.dest;
  assign do_is_load = de_q.is_load;
  assign do_valid   = de_q.valid;

endmodule

// File: doc/qm_decode.md
# qm_decode

Instruction decode stage of the q3kmips pipeline: consumes the fetch-stage IR/NextPC pair, reads the 32×32 general-purpose register file, generates the extended immediate and destination register, and registers everything into the Decode/Execute pipeline register. It owns the register-file write port used by writeback. It detects load-use hazards and inserts one bubble while back-pressuring fetch.

## Interface
Parameters:
- none (widths fixed by the MIPS32 ISA; constants live in the package)

Ports:
- sys_clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- di_IR  in  32  instruction from fetch
- di_NextPC  in  32  PC+4 from fetch
- di_valid  in  1  di_IR holds a real instruction
- ex_stall  in  1  execute cannot accept; hold DE register
- wb_enable  in  1  register-file write strobe
- wb_reg  in  5  write address
- wb_data  in  32  write data
- do_stall  out  1  fetch must hold its FD register this cycle
- do_A  out  32  rs operand
- do_B  out  32  rt operand
- do_Imm  out  32  extended immediate
- do_IR  out  32  instruction
- do_NextPC  out  32  PC+4
- do_Dest  out  5  destination register (0 = no write)
- do_is_load  out  1  instruction is LB/LH/LW/LBU/LHU
- do_valid  out  1  DE register holds a real instruction

## Operation
- Register file: 32×32 flops, written on sys_clk rising edge when wb_enable && wb_reg != 0. Reads combinational on di_IR[25:21] and di_IR[20:16]. Register 0 always reads 0.
- Immediate: ANDI/ORI/XORI (0x0C–0x0E) zero-extend; LUI (0x0F) yields {imm,16'h0}; all others sign-extend di_IR[15:0].
- Dest: opcode 0 → rd; JAL → 31; loads, ALU-immediate ops and LUI → rt; stores, branches, J and unknown opcodes → 0.
- Load-use hazard: do_valid && do_is_load && do_Dest != 0 && do_Dest equals rs or rt of a valid di_IR. On a hazard, the DE register loads a bubble (do_valid=0, do_Dest=0, do_IR=0) and do_stall=1.
- do_stall = ex_stall | hazard.
- Priority when ex_stall=1: the DE register holds all fields unchanged, and hazard does not insert a bubble.
- di_valid=0: the DE register loads a bubble.

## Timing
- Latency: one cycle from di_* to do_*.
- Register-file write is visible to a read in the next cycle. Same-cycle visibility is set by QM_DECODE_BYPASS_EN.
- Hazard bubble lasts exactly one cycle. The next cycle the load is in execute, do_Dest no longer matches, and the held instruction issues.
- Reset (asynchronous assert, synchronous deassert by the top level): all do_* = 0, do_valid = 0, all 32 registers = 0. Reset mid-stall discards the held instruction.

## Configuration
- QM_DECODE_BYPASS_EN defined: when wb_enable && wb_reg != 0 && wb_reg matches a read address, the read returns wb_data in the same cycle (write-through).
- QM_DECODE_BYPASS_EN undefined: reads return the pre-write value. Software or the hazard unit must cover the one-cycle writeback gap.

## Structure
- Package qm_pkg holds:
  - opcode constants (OP_SPECIAL, OP_J, OP_JAL, OP_LW, OP_LUI, …)
  - field slice positions
  - the register-address typedef (5 bits)
- One sub-module, qm_regfile, contains:
  - the storage array
  - 2 read ports and 1 write port
  - the bypass macro logic
- qm_decode keeps the immediate, dest and hazard logic plus the DE register.

## Test plan
- Reset:
  - Stimulus: reset low, with di_IR=ADDI $1,$0,5 and di_valid=1.
  - Required response: do_valid=0 and all outputs 0 while reset is low. The first edge after release gives do_Imm=5, do_Dest=1, do_A=0.
- Writeback then read:
  - Stimulus: wb $3←0xDEADBEEF, then decode ADD $4,$3,$3.
  - Required response: do_A = do_B = 0xDEADBEEF.
  - Same-cycle write/read: returns 0xDEADBEEF only with QM_DECODE_BYPASS_EN.
- Immediate forms:
  - ORI imm 0x8000 → do_Imm = 0x00008000.
  - ADDI imm 0x8000 → do_Imm = 0xFFFF8000.
  - LUI imm 0x1234 → do_Imm = 0x12340000.
- Load-use:
  - Stimulus: LW $5,0($2) followed by ADD $6,$5,$1.
  - Required response: do_stall=1 for one cycle and one bubble (do_valid=0); ADD issues the following cycle.
- ex_stall priority:
  - Stimulus: ex_stall=1 for 3 cycles during the load-use case.
  - Required response: the DE register stays frozen on LW, do_stall=1 throughout, and no bubble appears until ex_stall drops.
- $0 writes:
  - Stimulus: wb_enable with wb_reg=0, wb_data=0xFFFFFFFF.
  - Required response: a subsequent read of $0 returns 0.
